// File: rtl/maze_env_responder.sv
// Handshaked 8x8 grid-maze environment for the Q-learning agent.
// Owns current state, step and episode counters; one registered step per action.
module maze_env_responder #(
  parameter logic [5:0]         START_STATE = 6'd0,
  parameter logic [5:0]         GOAL_STATE  = 6'd63,
  parameter logic [7:0]         MAX_STEPS   = 8'd64,
  parameter logic [63:0]        WALL_MAP    = 64'h0,
  parameter logic signed [15:0] REWARD_GOAL = 16'sd100,
  parameter logic signed [15:0] REWARD_STEP = -16'sd1,
  parameter logic signed [15:0] REWARD_WALL = -16'sd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        act_valid,
  output logic        act_ready,
  input  logic [3:0]  action,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  current_state,
  output logic [5:0]  next_state,
  output logic [15:0] reward,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  step_count,
  output logic [15:0] episode_count
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_e;

  state_e st_q, st_d;

  logic [3:0]         act_q, act_d;
  logic [5:0]         cur_q, cur_d;
  logic [5:0]         nxt_q, nxt_d;
  logic signed [15:0] rew_q, rew_d;
  logic               done_q, done_d;
  logic               to_q, to_d;
  logic [7:0]         step_q, step_d;
  logic [15:0]        ep_q, ep_d;

  logic [2:0] row, col;
  logic [5:0] cand;
  logic       onehot, edge_blk, blocked, goal, limit;
  logic [7:0] step_inc;

  assign row = cur_q[5:3];
  assign col = cur_q[2:0];

  always_comb begin
    cand     = cur_q;
    edge_blk = 1'b0;
    onehot   = (act_q != 4'd0) && ((act_q & (act_q - 4'd1)) == 4'd0);
    // Decode only a clean one-hot action; anything else is an illegal move.
    if (onehot) begin
      unique case (1'b1)
        act_q[0]: begin
          if (row == 3'd0) edge_blk = 1'b1;
          else cand = {row - 3'd1, col};
        end
        act_q[1]: begin
          if (row == 3'd7) edge_blk = 1'b1;
          else cand = {row + 3'd1, col};
        end
        act_q[2]: begin
          if (col == 3'd0) edge_blk = 1'b1;
          else cand = {row, col - 3'd1};
        end
        act_q[3]: begin
          if (col == 3'd7) edge_blk = 1'b1;
          else cand = {row, col + 3'd1};
        end
        default: edge_blk = 1'b1;
      endcase
    end
  end

  assign blocked  = !onehot || edge_blk || WALL_MAP[cand];
  assign goal     = !blocked && (cand == GOAL_STATE);
  assign step_inc = step_q + 8'd1;
  assign limit    = (step_inc == MAX_STEPS);

  always_comb begin
    st_d   = st_q;
    act_d  = act_q;
    cur_d  = cur_q;
    nxt_d  = nxt_q;
    rew_d  = rew_q;
    done_d = done_q;
    to_d   = to_q;
    step_d = step_q;
    ep_d   = ep_q;
    case (st_q)
      IDLE: begin
        if (act_valid && en) begin
          act_d = action;
          st_d  = CALC;
        end
      end
      CALC: begin
        step_d = step_inc;
        nxt_d  = blocked ? cur_q : cand;
        rew_d  = blocked ? REWARD_WALL :
                 goal    ? REWARD_GOAL : REWARD_STEP;
        // Goal outranks the step limit on the same step.
        done_d = goal || limit;
        to_d   = !goal && limit;
        st_d   = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (done_q) begin
            cur_d  = START_STATE;
            nxt_d  = START_STATE;
            step_d = 8'd0;
            if (ep_q != 16'hFFFF) ep_d = ep_q + 16'd1;
          end else begin
            cur_d = nxt_q;
          end
          done_d = 1'b0;
          to_d   = 1'b0;
          st_d   = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      act_q  <= 4'd0;
      cur_q  <= START_STATE;
      nxt_q  <= START_STATE;
      rew_q  <= 16'sd0;
      done_q <= 1'b0;
      to_q   <= 1'b0;
      step_q <= 8'd0;
      ep_q   <= 16'd0;
    end else begin
      st_q   <= st_d;
      act_q  <= act_d;
      cur_q  <= cur_d;
      nxt_q  <= nxt_d;
      rew_q  <= rew_d;
      done_q <= done_d;
      to_q   <= to_d;
      step_q <= step_d;
      ep_q   <= ep_d;
    end
  end

  assign act_ready     = rst_n && en && (st_q == IDLE);
  assign rsp_valid     = (st_q == RESP);
  assign current_state = cur_q;
  assign next_state    = nxt_q;
  assign reward        = rew_q;
  assign done          = done_q;
  assign timeout       = to_q;
  assign step_count    = step_q;
  assign episode_count = ep_q;

endmodule

// File: tb/tb_maze_env_responder.sv
// Directed bench: two responders (open maze / walled, short limit)
// driven in lockstep, checked against hand-computed responses.
module tb_maze_env_responder;

  logic clk = 1'b0;
  logic rst_n, en, act_valid, rsp_ready;
  logic [3:0] action;

  logic a_ardy, a_rv, a_dn, a_to;
  logic [5:0] a_cur, a_ns;
  logic [15:0] a_rw, a_ep;
  logic [7:0] a_sc;

  logic b_ardy, b_rv, b_dn, b_to;
  logic [5:0] b_cur, b_ns;
  logic [15:0] b_rw, b_ep;
  logic [7:0] b_sc;

  int errs = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  maze_env_responder dut_a (
    .clk(clk), .rst_n(rst_n), .en(en),
    .act_valid(act_valid), .act_ready(a_ardy),
    .action(action), .rsp_valid(a_rv),
    .rsp_ready(rsp_ready), .current_state(a_cur),
    .next_state(a_ns), .reward(a_rw), .done(a_dn),
    .timeout(a_to), .step_count(a_sc),
    .episode_count(a_ep)
  );

  maze_env_responder #(
    .MAX_STEPS(8'd4),
    .WALL_MAP(64'h2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .act_valid(act_valid), .act_ready(b_ardy),
    .action(action), .rsp_valid(b_rv),
    .rsp_ready(rsp_ready), .current_state(b_cur),
    .next_state(b_ns), .reward(b_rw), .done(b_dn),
    .timeout(b_to), .step_count(b_sc),
    .episode_count(b_ep)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    act_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one action, wait for the response (sampled at negedge),
  // leave the handshake to complete at the following posedge.
  task automatic do_step(input logic [3:0] a);
    @(negedge clk);
    action = a;
    act_valid = 1'b1;
    rsp_ready = 1'b1;
    check("ardy", a_ardy, 1);
    @(posedge clk);
    #1 act_valid = 1'b0;
    lat = 0;
    while (!a_rv && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 2);
  endtask

  task automatic exp_a(input string t, input logic [5:0] ns,
                       input logic [15:0] rw, input logic dn,
                       input logic to, input logic [7:0] sc);
    check({t, ".a.ns"}, a_ns, ns);
    check({t, ".a.rw"}, a_rw, rw);
    check({t, ".a.dn"}, a_dn, dn);
    check({t, ".a.to"}, a_to, to);
    check({t, ".a.sc"}, a_sc, sc);
  endtask

  task automatic exp_b(input string t, input logic [5:0] ns,
                       input logic [15:0] rw, input logic dn,
                       input logic to, input logic [7:0] sc);
    check({t, ".b.ns"}, b_ns, ns);
    check({t, ".b.rw"}, b_rw, rw);
    check({t, ".b.dn"}, b_dn, dn);
    check({t, ".b.to"}, b_to, to);
    check({t, ".b.sc"}, b_sc, sc);
  endtask

  task automatic finish_hs();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    act_valid = 1'b0;
    rsp_ready = 1'b0;
    action = 4'd0;
    #2;
    check("rst.ardy", a_ardy, 0);
    check("rst.rv", a_rv, 0);
    check("rst.cur", a_cur, 0);
    check("rst.ns", a_ns, 0);
    check("rst.rw", a_rw, 0);
    check("rst.sc", a_sc, 0);
    check("rst.ep", a_ep, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.ardy", a_ardy, 1);

    // en low blocks acceptance
    en = 1'b0;
    act_valid = 1'b1;
    action = 4'b1000;
    repeat (3) @(negedge clk);
    check("en0.ardy", a_ardy, 0);
    check("en0.rv", a_rv, 0);
    act_valid = 1'b0;
    en = 1'b1;

    // Backpressure, then reset while in RESP
    @(negedge clk);
    action = 4'b1000;
    act_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 act_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp.rv", a_rv, 1);
      check("bp.ardy", a_ardy, 0);
      check("bp.ns", a_ns, 1);
      check("bp.rw", a_rw, 16'hFFFF);
      check("bp.sc", a_sc, 1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("rr.ardy", a_ardy, 0);
    check("rr.rv", a_rv, 0);
    check("rr.cur", a_cur, 0);
    check("rr.ns", a_ns, 0);
    check("rr.rw", a_rw, 0);
    check("rr.dn", a_dn, 0);
    check("rr.sc", a_sc, 0);
    check("rr.ep", a_ep, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Edge, illegal, wall and timeout on the short-limit DUT
    do_step(4'b0001);
    exp_a("up0", 6'd0, 16'hFFF6, 0, 0, 8'd1);
    exp_b("up0", 6'd0, 16'hFFF6, 0, 0, 8'd1);
    finish_hs();
    do_step(4'b0011);
    exp_a("ill", 6'd0, 16'hFFF6, 0, 0, 8'd2);
    exp_b("ill", 6'd0, 16'hFFF6, 0, 0, 8'd2);
    finish_hs();
    do_step(4'b1000);
    exp_a("rt", 6'd1, 16'hFFFF, 0, 0, 8'd3);
    exp_b("wall", 6'd0, 16'hFFF6, 0, 0, 8'd3);
    finish_hs();
    check("rt.a.cur", a_cur, 1);
    do_step(4'b0010);
    exp_a("dn", 6'd9, 16'hFFFF, 0, 0, 8'd4);
    exp_b("dn", 6'd8, 16'hFFFF, 1, 1, 8'd4);
    finish_hs();
    check("dn.a.cur", a_cur, 9);
    check("dn.a.ep", a_ep, 0);
    check("to.b.cur", b_cur, 0);
    check("to.b.sc", b_sc, 0);
    check("to.b.ep", b_ep, 1);
    check("to.b.ardy", b_ardy, 1);

    // Four legal moves: timeout with step reward
    do_reset();
    do_step(4'b0010);
    do_step(4'b1000);
    do_step(4'b1000);
    do_step(4'b1000);
    exp_b("to4", 6'd11, 16'hFFFF, 1, 1, 8'd4);
    exp_a("to4", 6'd11, 16'hFFFF, 0, 0, 8'd4);
    finish_hs();
    check("to4.b.cur", b_cur, 0);
    check("to4.b.ep", b_ep, 1);

    // Walk to the goal on the open maze
    do_reset();
    for (int i = 0; i < 7; i++) do_step(4'b0010);
    for (int i = 0; i < 6; i++) do_step(4'b1000);
    finish_hs();
    check("pre.a.cur", a_cur, 62);
    do_step(4'b1000);
    exp_a("goal", 6'd63, 16'd100, 1, 0, 8'd14);
    finish_hs();
    check("goal.a.cur", a_cur, 0);
    check("goal.a.sc", a_sc, 0);
    check("goal.a.ep", a_ep, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
